regfile_alu_datapath: RTL and testbench
=======================================

Name: regfile_alu_datapath

Overview:
Parametrised successor of the team's register-file/ALU datapath. It loads registers from a selectable lane of a wide input port, executes ALU operations on two read ports, and drives a registered result Y with a flag. Over the previous generation it adds generic widths, lane count and register depth, a start/ready issue handshake, an out_valid strobe and a multi-cycle multiply. It sits between the input bus and the display/output stage.

Parameters:
DATA_W, 8, width of registers, operands and result Y
NB_REGS, 16, number of registers (power of two, >=2)
NB_LANES, 8, number of DATA_W lanes on in_port
AW, $clog2(NB_REGS), register address width (derived)
SW, $clog2(NB_LANES), lane select width (derived)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active high
in_port  in  NB_LANES*DATA_W  input lanes; lane k = bits [k*DATA_W +: DATA_W]
sel  in  SW  lane selected for a register write
wen  in  1  write enable: reg[wa] <= lane sel
wa  in  AW  write address
raa  in  AW  operand A address
rab  in  AW  operand B address
op  in  3  operation code, sampled at issue
start  in  1  issue request
ready  out  1  high when an issue is accepted this cycle
out_port  out  DATA_W  registered result Y
out_valid  out  1  one-cycle pulse when Y (or flag) is updated
flag  out  1  registered status of the last completed operation

Behaviour:
- Reset (async, rst=1): all registers 0, out_port 0, flag 0, out_valid 0, FSM IDLE, ready 1. Reset during MUL aborts it; no out_valid is produced.
- Write: on an edge with wen=1, reg[wa] <= lane sel. Allowed in any FSM state. If sel >= NB_LANES, the write is ignored.
- Issue: accepted on an edge where start=1, wen=0 and the FSM is IDLE. ready = (state==IDLE) & !wen. start while ready=0 is dropped, not queued.
- Operands A = reg[raa] and B = reg[rab] are read combinationally and latched at issue. Later writes do not affect an op in flight.
- op encoding and effect (Y = out_port, width DATA_W, wrap-around modulo 2^DATA_W):
  - 000 ADD: Y=A+B; flag=carry out
  - 001 SUB: Y=A-B; flag=borrow (A<B unsigned)
  - 010 CMP: Y unchanged; flag=(A==B)
  - 011 AND: Y=A&B; flag=(Y==0)
  - 100 OR: Y=A|B; flag=(Y==0)
  - 101 XOR: Y=A^B; flag=(Y==0)
  - 110 MUL: Y=low DATA_W bits of A*B unsigned; flag=(high half != 0)
  - 111 PASS: Y=A; flag=0
- Single-cycle ops (all except MUL): Y and flag update on the issue edge. out_valid is 1 for exactly the following cycle. The FSM stays IDLE, so back-to-back issue is allowed every cycle.
- MUL: FSM IDLE->MUL on issue. Shift-add over DATA_W cycles using an internal 2*DATA_W accumulator and a counter.
  - On the final step: Y and flag update, out_valid pulses, FSM returns to IDLE.
  - Latency: issue edge at cycle t -> out_valid high in cycle t+DATA_W. ready=0 from t+1 until the FSM is back in IDLE.
- out_port holds its value except at the update edges above. wen-only cycles and CMP never change out_port.
- wen=1 together with start=1: the write occurs and the issue is rejected.
- Same-cycle write to a register that is being read at issue: the operand takes the pre-write value.
- out_valid is 0 in every cycle not listed above.

Test Plan:
- Reset: assert rst mid-MUL -> out_port=0, flag=0, out_valid=0, ready=1 during and after reset; no late out_valid.
- Write then ADD: in_port lane3=0xF0, sel=3, wen, wa=1; lane0=0x20, sel=0, wa=2; issue ADD raa=1 rab=2 -> next cycle out_port=0x10, flag=1, out_valid=1 for one cycle.
- SUB/CMP: reg1=5, reg2=9. SUB -> Y=0xFC, flag=1. Then CMP reg2,reg2 -> flag=1 with Y still 0xFC.
- MUL latency: reg1=0x12, reg2=0x10, issue MUL at t -> ready=0 for t+1..t+7; out_valid at t+8 with Y=0x20 and flag=1 (product 0x120). A start during busy is dropped.
- Conflicts: wen=1 and start=1 in the same cycle -> register written, no out_valid. Write with sel=NB_LANES-1 OK; a parametrised sel out of range (NB_LANES=6, sel=7) -> register unchanged.
- Stability: 50 cycles of random wen-only traffic -> out_port stable and out_valid=0 throughout.

Source files
------------

// File: rtl/regfile_alu_datapath.sv
// Register file + ALU datapath: lane-selected register writes, two read ports, registered Y/flag.
// Latency: single-cycle ops give out_valid the next cycle; MUL gives out_valid DATA_W cycles after issue.
// Backpressure: ready low while MUL runs or wen is high; a start while not ready is dropped.
module regfile_alu_datapath #(
    parameter int DATA_W   = 8,
    parameter int NB_REGS  = 16,
    parameter int NB_LANES = 8,
    parameter int AW       = $clog2(NB_REGS),
    parameter int SW       = $clog2(NB_LANES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_LANES*DATA_W-1:0]   in_port,
    input  logic [SW-1:0]                sel,
    input  logic                         wen,
    input  logic [AW-1:0]                wa,
    input  logic [AW-1:0]                raa,
    input  logic [AW-1:0]                rab,
    input  logic [2:0]                   op,
    input  logic                         start,
    output logic                         ready,
    output logic [DATA_W-1:0]            out_port,
    output logic                         out_valid,
    output logic                         flag
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_CMP  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    typedef struct packed {
        logic [2*DATA_W-1:0] acc;
        logic [2*DATA_W-1:0] mcand;
        logic [DATA_W-1:0]   mplier;
        logic [CW-1:0]       cnt;
    } mul_t;

    logic [DATA_W-1:0]   regs [NB_REGS];
    state_e              state;
    mul_t                mul;

    logic [DATA_W-1:0]   lane_dat;
    logic                lane_ok;
    logic [DATA_W-1:0]   opa, opb;
    logic [DATA_W:0]     add_w, sub_w;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_flag;
    logic [2*DATA_W-1:0] mul_sum;
    logic                issue;

    always_comb begin
        lane_dat = '0;
        for (int k = 0; k < NB_LANES; k++) begin
            if (int'(sel) == k) lane_dat = in_port[k*DATA_W +: DATA_W];
        end
    end
    assign lane_ok = int'(sel) < NB_LANES;

    assign opa   = regs[raa];
    assign opb   = regs[rab];
    assign ready = (state == S_IDLE) && !wen;
    assign issue = start && ready;

    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = {1'b0, opa} - {1'b0, opb};

    always_comb begin
        alu_y    = out_port;
        alu_flag = 1'b0;
        case (op_e'(op))
            OP_ADD:  begin alu_y = add_w[DATA_W-1:0]; alu_flag = add_w[DATA_W]; end
            OP_SUB:  begin alu_y = sub_w[DATA_W-1:0]; alu_flag = sub_w[DATA_W]; end
            OP_CMP:  alu_flag = (opa == opb);
            OP_AND:  begin alu_y = opa & opb; alu_flag = ~|(opa & opb); end
            OP_OR:   begin alu_y = opa | opb; alu_flag = ~|(opa | opb); end
            OP_XOR:  begin alu_y = opa ^ opb; alu_flag = ~|(opa ^ opb); end
            OP_PASS: alu_y = opa;
            default: alu_flag = 1'b0;
        endcase
    end

    // Partial product for the current multiplier bit; bit 0 is folded in at issue.
    assign mul_sum = mul.acc + (mul.mplier[0] ? mul.mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_REGS; i++) regs[i] <= '0;
            state     <= S_IDLE;
            mul       <= '0;
            out_port  <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (wen && lane_ok) regs[wa] <= lane_dat;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (op_e'(op) == OP_MUL) begin
                            state      <= S_MUL;
                            mul.acc    <= opb[0] ? {{DATA_W{1'b0}}, opa} : '0;
                            mul.mcand  <= {{DATA_W{1'b0}}, opa} << 1;
                            mul.mplier <= opb >> 1;
                            mul.cnt    <= CW'(1);
                        end else begin
                            out_port  <= alu_y;
                            flag      <= alu_flag;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    mul.acc    <= mul_sum;
                    mul.mcand  <= mul.mcand << 1;
                    mul.mplier <= mul.mplier >> 1;
                    mul.cnt    <= mul.cnt + CW'(1);
                    if (mul.cnt == CW'(DATA_W-1)) begin
                        out_port  <= mul_sum[DATA_W-1:0];
                        flag      <= |mul_sum[2*DATA_W-1:DATA_W];
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Randomised bench for regfile_alu_datapath with a queue scoreboard and an arithmetic reference model.
module tb_regfile_alu_datapath;
    localparam int W   = 8;
    localparam int NR  = 16;
    localparam int NL  = 8;
    localparam int AW  = 4;
    localparam int SW  = 3;
    localparam int NL6 = 6;
    localparam int MOD = 1 << W;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_CMP = 2, OP_AND = 3;
    localparam int OP_OR = 4, OP_XOR = 5, OP_MUL = 6, OP_PASS = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NL*W-1:0] in_port;
    logic [SW-1:0]   sel;
    logic            wen, start, ready, out_valid, flag;
    logic [AW-1:0]   wa, raa, rab;
    logic [2:0]      op;
    logic [W-1:0]    out_port;

    logic [NL6*W-1:0] in_port6;
    logic [2:0]       sel6, op6;
    logic             wen6, start6, ready6, out_valid6, flag6;
    logic [AW-1:0]    wa6, raa6, rab6;
    logic [W-1:0]     out_port6;

    regfile_alu_datapath #(.DATA_W(W), .NB_REGS(NR), .NB_LANES(NL)) dut (
        .clk(clk), .rst(rst), .in_port(in_port), .sel(sel), .wen(wen), .wa(wa),
        .raa(raa), .rab(rab), .op(op), .start(start), .ready(ready),
        .out_port(out_port), .out_valid(out_valid), .flag(flag)
    );

    regfile_alu_datapath #(.DATA_W(W), .NB_REGS(NR), .NB_LANES(NL6)) dut6 (
        .clk(clk), .rst(rst), .in_port(in_port6), .sel(sel6), .wen(wen6), .wa(wa6),
        .raa(raa6), .rab(rab6), .op(op6), .start(start6), .ready(ready6),
        .out_port(out_port6), .out_valid(out_valid6), .flag(flag6)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         f;
        int           at;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q[$];
    exp_t q6[$];
    logic [W-1:0] m [NR];
    logic [W-1:0] my;
    int idle_from = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NL*W-1:0] rnd_lanes();
        logic [NL*W-1:0] l;
        for (int i = 0; i < NL; i++) l[i*W +: W] = W'($urandom());
        return l;
    endfunction

    // One bench cycle: apply inputs, check ready, and advance the reference model.
    task automatic step(input bit w, input int s, input int a, input int ra, input int rb,
                        input int o, input bit st, input logic [NL*W-1:0] lanes);
        int unsigned ai, bi, r;
        int c;
        bit rdy;
        exp_t e;
        @(posedge clk);
        #1;
        wen = w; sel = SW'(s); wa = AW'(a); raa = AW'(ra); rab = AW'(rb);
        op = 3'(o); start = st; in_port = lanes;
        c = cyc;
        rdy = (c >= idle_from) && !w;
        #1 chk("ready", {31'b0, ready}, {31'b0, rdy});
        if (st && rdy) begin
            ai = m[ra];
            bi = m[rb];
            e.at = c + 1;
            e.f = 1'b0;
            case (o)
                OP_ADD:  begin r = ai + bi; e.y = W'(r % MOD); e.f = (r >= MOD); end
                OP_SUB:  begin e.y = W'((ai + MOD - bi) % MOD); e.f = (ai < bi); end
                OP_CMP:  begin e.y = my; e.f = (ai == bi); end
                OP_AND:  begin e.y = W'(ai & bi); e.f = (e.y == 0); end
                OP_OR:   begin e.y = W'(ai | bi); e.f = (e.y == 0); end
                OP_XOR:  begin e.y = W'(ai ^ bi); e.f = (e.y == 0); end
                OP_MUL:  begin
                    r = ai * bi;
                    e.y = W'(r % MOD);
                    e.f = ((r / MOD) != 0);
                    e.at = c + W;
                    idle_from = c + W;
                end
                default: e.y = W'(ai);
            endcase
            my = e.y;
            q.push_back(e);
        end
        if (w && s < NL) m[a] = lanes[s*W +: W];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, rnd_lanes());
    endtask

    task automatic wr(input int a, input logic [W-1:0] v);
        logic [NL*W-1:0] l;
        int k;
        l = rnd_lanes();
        k = $urandom_range(0, NL-1);
        l[k*W +: W] = v;
        step(1, k, a, 0, 0, 0, 0, l);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1; wen = 1'b0; start = 1'b0;
        q.delete();
        for (int i = 0; i < NR; i++) m[i] = '0;
        my = '0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        idle_from = cyc;
    endtask

    initial begin : mon
        logic [W-1:0] cy;
        logic cf;
        exp_t e;
        cy = '0;
        cf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_out_port", {24'b0, out_port}, 32'h0);
                chk("rst_flag", {31'b0, flag}, 32'h0);
                chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
                chk("rst_ready", {31'b0, ready}, 32'h1);
                cy = '0;
                cf = 1'b0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.at);
                    chk("y", {24'b0, out_port}, {24'b0, e.y});
                    chk("flag", {31'b0, flag}, {31'b0, e.f});
                    cy = e.y;
                    cf = e.f;
                end
            end else begin
                chk("hold_y", {24'b0, out_port}, {24'b0, cy});
                chk("hold_flag", {31'b0, flag}, {31'b0, cf});
                if (q.size() > 0 && q[0].at <= cyc) begin
                    chk("missing_out_valid", 32'h0, 32'h1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin : mon6
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid6) begin
                if (q6.size() == 0) begin
                    chk("lanes6_unexpected_out_valid", 32'h1, 32'h0);
                end else begin
                    e = q6.pop_front();
                    chk("lanes6_valid_cycle", cyc, e.at);
                    chk("lanes6_y", {24'b0, out_port6}, {24'b0, e.y});
                    chk("lanes6_flag", {31'b0, flag6}, {31'b0, e.f});
                end
            end
        end
    end

    initial begin : drv6
        logic [NL6*W-1:0] l6;
        exp_t e;
        wen6 = 1'b0; start6 = 1'b0; sel6 = '0; wa6 = '0; raa6 = '0; rab6 = '0;
        op6 = '0; in_port6 = '0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < NL6; i++) l6[i*W +: W] = W'(8'hA0 + i);
        l6[5*W +: W] = 8'h5A;
        wen6 = 1'b1; sel6 = 3'd5; wa6 = 4'd1; in_port6 = l6;
        @(posedge clk);
        #1;
        for (int i = 0; i < NL6; i++) l6[i*W +: W] = 8'hC3;
        sel6 = 3'd7; in_port6 = l6;
        @(posedge clk);
        #1 sel6 = 3'd6;
        @(posedge clk);
        #1;
        wen6 = 1'b0; start6 = 1'b1; op6 = 3'(OP_PASS); raa6 = 4'd1;
        e.y = 8'h5A; e.f = 1'b0; e.at = cyc + 1;
        q6.push_back(e);
        @(posedge clk);
        #1 start6 = 1'b0;
    end

    initial begin : drv
        bit w, st;
        logic [NL*W-1:0] l;
        rst = 1'b0; wen = 1'b0; start = 1'b0; sel = '0; wa = '0; raa = '0; rab = '0;
        op = '0; in_port = '0; my = '0;
        for (int i = 0; i < NR; i++) m[i] = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_from = cyc;

        l = rnd_lanes(); l[3*W +: W] = 8'hF0; step(1, 3, 1, 0, 0, 0, 0, l);
        l = rnd_lanes(); l[0 +: W] = 8'h20;   step(1, 0, 2, 0, 0, 0, 0, l);
        step(0, 0, 0, 1, 2, OP_ADD, 1, rnd_lanes());
        idle(2);

        wr(1, 8'h05); wr(2, 8'h09);
        step(0, 0, 0, 1, 2, OP_SUB, 1, rnd_lanes());
        step(0, 0, 0, 2, 2, OP_CMP, 1, rnd_lanes());
        idle(2);

        wr(1, 8'h12); wr(2, 8'h10);
        step(0, 0, 0, 1, 2, OP_MUL, 1, rnd_lanes());
        step(0, 0, 0, 1, 2, OP_ADD, 1, rnd_lanes());
        wr(1, 8'hFF);
        for (int i = 0; i < W - 3; i++) step(0, 0, 0, 2, 2, OP_PASS, 1, rnd_lanes());
        idle(3);

        l = rnd_lanes(); l[7*W +: W] = 8'h3C;
        step(1, 7, 3, 3, 3, OP_PASS, 1, l);
        step(0, 0, 0, 3, 3, OP_PASS, 1, rnd_lanes());
        step(0, 0, 0, 3, 1, OP_MUL, 1, rnd_lanes());
        idle(W + 1);

        step(0, 0, 0, 1, 2, OP_MUL, 1, rnd_lanes());
        idle(3);
        do_reset(2);
        idle(W + 2);
        step(0, 0, 0, 1, 2, OP_PASS, 1, rnd_lanes());
        idle(2);

        for (int i = 0; i < 50; i++)
            step(1, $urandom_range(0, NL-1), $urandom_range(0, NR-1), 0, 0, 0, 0, rnd_lanes());

        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 9) < 3);
            st = ($urandom_range(0, 9) < 7);
            step(w, $urandom_range(0, NL-1), $urandom_range(0, NR-1), $urandom_range(0, NR-1),
                 $urandom_range(0, NR-1), $urandom_range(0, 7), st, rnd_lanes());
        end
        idle(W + 4);
        chk("queue_drained", q.size(), 32'h0);
        chk("lanes6_queue_drained", q6.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
